// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_if_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} fetch_state_e;

   localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/stage_if_fetch_skid_buffer.sv
// One-entry holding register for a fetched word that decode could not take.
module fetch_skid_buffer #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          unload,
   input  logic          clear,
   input  logic [DW-1:0] wr_inst,
   input  logic [AW-1:0] wr_pc_plus4,
   output logic          full,
   output logic [DW-1:0] inst,
   output logic [AW-1:0] pc_plus4
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full     <= 1'b0;
         inst     <= '0;
         pc_plus4 <= '0;
      end else if (clear || unload) begin
         full <= 1'b0;
      end else if (load) begin
         full     <= 1'b1;
         inst     <= wr_inst;
         pc_plus4 <= wr_pc_plus4;
      end
   end

endmodule

// File: rtl/stage_if.sv
// Fetch stage: owns the PC, drives the req/ack instruction bus and the IF/ID register.
module stage_if
   import stage_if_pkg::*;
#(
   parameter int                         DATA_IBUS_WIDTH = 32,
   parameter int                         ADDR_IBUS_WIDTH = 32,
   parameter logic [ADDR_IBUS_WIDTH-1:0] RESET_PC        = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   output logic [ADDR_IBUS_WIDTH-1:0] o_ibus_addr,
   output logic                       o_ibus_req,
   input  logic                       i_ibus_ack,
   input  logic [DATA_IBUS_WIDTH-1:0] i_ibus_rdata,
   input  logic                       i_stall,
   input  logic                       i_redirect,
   input  logic [ADDR_IBUS_WIDTH-1:0] i_redirect_pc,
   output logic [DATA_IBUS_WIDTH-1:0] o_inst,
   output logic [ADDR_IBUS_WIDTH-1:0] o_pc_plus4,
   output logic                       o_valid
);

   localparam int DW = DATA_IBUS_WIDTH;
   localparam int AW = ADDR_IBUS_WIDTH;

   fetch_state_e  state, state_nxt;
   logic [AW-1:0] pc, pc_nxt, target, target_nxt, pc_plus4, redir_pc;
   logic          buf_load, buf_unload, buf_clear, buf_full, fetch_take;
   logic [DW-1:0] buf_inst;
   logic [AW-1:0] buf_pc_plus4;

   assign redir_pc    = i_redirect_pc & ~AW'(3);
   assign pc_plus4    = pc + AW'(4);
   assign o_ibus_addr = pc;

   fetch_skid_buffer #(.DW(DW), .AW(AW)) u_skid (
      .clk        (i_clk),
      .rst_n      (i_rst),
      .load       (buf_load),
      .unload     (buf_unload),
      .clear      (buf_clear),
      .wr_inst    (i_ibus_rdata),
      .wr_pc_plus4(pc_plus4),
      .full       (buf_full),
      .inst       (buf_inst),
      .pc_plus4   (buf_pc_plus4)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         target <= RESET_PC;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         target <= target_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      target_nxt = target;
      o_ibus_req = 1'b0;
      buf_load   = 1'b0;
      buf_unload = 1'b0;
      buf_clear  = 1'b0;
      fetch_take = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
            if (i_redirect) pc_nxt = redir_pc;
         end
         FETCH: begin
            o_ibus_req = 1'b1;
            if (i_ibus_ack) begin
               if (i_redirect) begin
                  pc_nxt = redir_pc;
               end else begin
                  pc_nxt = pc_plus4;
                  if (i_stall) begin
                     buf_load  = 1'b1;
                     state_nxt = HOLD;
                  end else begin
                     fetch_take = 1'b1;
                  end
               end
            end else if (i_redirect) begin
               // Bus transaction stays open; remember where to go once it drains.
               target_nxt = redir_pc;
               state_nxt  = DRAIN;
            end
         end
         HOLD: begin
            if (i_redirect) begin
               buf_clear = 1'b1;
               pc_nxt    = redir_pc;
               state_nxt = FETCH;
            end else if (!i_stall) begin
               buf_unload = 1'b1;
               state_nxt  = FETCH;
            end
         end
         DRAIN: begin
            o_ibus_req = 1'b1;
            if (i_redirect) target_nxt = redir_pc;
            if (i_ibus_ack) begin
               pc_nxt    = i_redirect ? redir_pc : target;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Redirect beats stall; the PC+4 field is left untouched on a flush.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_inst     <= DW'(INST_NOP);
         o_pc_plus4 <= RESET_PC;
         o_valid    <= 1'b0;
      end else if (i_redirect) begin
         o_inst  <= DW'(INST_NOP);
         o_valid <= 1'b0;
      end else if (i_stall) begin
         o_inst  <= o_inst;
      end else if (buf_full) begin
         o_inst     <= buf_inst;
         o_pc_plus4 <= buf_pc_plus4;
         o_valid    <= 1'b1;
      end else if (fetch_take) begin
         o_inst     <= i_ibus_rdata;
         o_pc_plus4 <= pc_plus4;
         o_valid    <= 1'b1;
      end else begin
         o_inst  <= DW'(INST_NOP);
         o_valid <= 1'b0;
      end
   end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage: the producer side of the IF/ID pipeline interface that the decode stage consumes (instruction word plus PC+4).
- Owns the PC and issues fetches on the instruction bus using a req/ack handshake with variable latency.
- Holds one fetched word in a skid buffer when decode stalls.
- Accepts branch/jump redirects from later stages and squashes wrong-path instructions.

Parameters:
- DATA_IBUS_WIDTH, 32, instruction bus data width.
- ADDR_IBUS_WIDTH, 32, instruction bus address and PC width.
- RESET_PC, 0, PC value after reset; must be word-aligned.

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_rst  in  1  reset; asynchronous, active-low.
- o_ibus_addr  out  ADDR_IBUS_WIDTH  fetch address; always the word-aligned PC.
- o_ibus_req  out  1  fetch request.
- i_ibus_ack  in  1  bus ack; i_ibus_rdata is valid in the same cycle.
- i_ibus_rdata  in  DATA_IBUS_WIDTH  fetched instruction.
- i_stall  in  1  decode cannot accept; IF/ID register holds.
- i_redirect  in  1  branch/jump taken; flush and refetch.
- i_redirect_pc  in  ADDR_IBUS_WIDTH  redirect target; bits [1:0] ignored (forced 0).
- o_inst  out  DATA_IBUS_WIDTH  IF/ID instruction.
- o_pc_plus4  out  ADDR_IBUS_WIDTH  IF/ID PC of the next sequential instruction.
- o_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (i_rst=0, async):
  - pc=RESET_PC, state=IDLE, buffer empty, o_ibus_req=0.
  - o_inst=NOP (all zeros), o_pc_plus4=RESET_PC, o_valid=0.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: req=0. Goes to FETCH on the first edge after reset release.
- FETCH: req=1, addr=pc.
  - Handshake: req and addr stay stable until ack. Zero-wait ack (same cycle as req) is legal.
  - ack & !redirect & !stall: IF/ID <= {rdata, pc+4, valid=1}; pc<=pc+4; stay in FETCH. Sustained throughput with zero-wait memory is 1 instruction/cycle.
  - ack & !redirect & stall: buffer <= {rdata, pc+4}; pc<=pc+4; go to HOLD.
  - ack & redirect: drop rdata; pc<=i_redirect_pc; stay in FETCH.
  - !ack & redirect: target<=i_redirect_pc; go to DRAIN. An outstanding bus transaction is never aborted.
- HOLD: req=0.
  - !stall & !redirect: IF/ID <= buffer, valid=1; buffer empties; go to FETCH.
  - redirect: buffer cleared; pc<=i_redirect_pc; go to FETCH.
- DRAIN: req=1 with the old address held.
  - ack: drop data; pc<=target; go to FETCH.
  - A new redirect while in DRAIN overwrites target (last one wins).
  - Redirect in the same cycle as ack: the new i_redirect_pc is used.
- IF/ID register priority, evaluated each edge:
  1. redirect -> o_valid=0, o_inst=NOP, o_pc_plus4 held. Redirect overrides stall.
  2. stall -> all three held.
  3. Buffer full -> load from buffer.
  4. FETCH & ack -> load from bus.
  5. Otherwise bubble: o_valid=0, o_inst=NOP.
- PC arithmetic is modulo 2^ADDR_IBUS_WIDTH. At 0xFFFFFFFC, pc+4 wraps to 0 with no flag.
- Buffer depth is 1. No request is issued while the buffer is full, so it never overflows.

Decomposition:
- Package types gets:
  - enum FetchState {IDLE, FETCH, HOLD, DRAIN};
  - constant INST_NOP = 32'h0000_0000.
- Sub-module fetch_skid_buffer: one-entry {inst, pc_plus4} register with load/unload/clear and a full flag.
- PC, FSM and the IF/ID register stay in stage_if.

Test Plan:
- Reset release with RESET_PC=0 and zero-wait memory returning addr as data -> fetch addresses 0x0,0x4,0x8 on consecutive cycles. IF/ID shows o_inst=0x0/o_pc_plus4=0x4, then 0x4/0x8, each with o_valid=1. Before release: o_valid=0, o_inst=0.
- ack delayed 3 cycles at addr 0x10 -> req and addr=0x10 held all 3 cycles; o_valid=0 throughout; one cycle after ack, o_valid=1 with o_pc_plus4=0x14.
- i_stall asserted when the ack for 0x8 arrives -> IF/ID holds the 0x4 instruction; req=0 during HOLD. One cycle after i_stall drops, IF/ID shows the 0x8 instruction with o_pc_plus4=0xC, and the fetch of 0xC begins.
- i_redirect=1 with i_redirect_pc=0x103, pending fetch of 0x20 with no ack -> DRAIN; the 0x20 data is discarded on ack. Next fetch address is 0x100; o_valid=0 until the 0x100 data arrives.
- Redirect to 0x40 while in HOLD with stall=1 -> buffer cleared; o_valid=0, o_inst=0; next request is to 0x40.
- PC=0xFFFFFFFC, zero-wait ack -> o_pc_plus4=0x0; next fetch address is 0x0. Also assert i_rst mid-DRAIN -> req drops immediately (asynchronously) and the first fetch after release is at RESET_PC.
